// File: rtl/dmem_mmio.sv
// Data-side memory responder for the single-cycle RV32 core.
// Decodes the data port into a word RAM and an MMIO page holding a
// free-running cycle counter, a GPIO output register and a byte TX FIFO.
// Reads are combinational; all state changes happen on the rising edge.
module dmem_mmio #(
  parameter int unsigned AW      = 6,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [1:0] RegCycles = 2'd0;
  localparam logic [1:0] RegGpio   = 2'd1;
  localparam logic [1:0] RegTxData = 2'd2;
  localparam logic [1:0] RegTxStat = 2'd3;

  logic [31:0]        mem      [0:2**AW-1];
  logic [7:0]         fifo_mem [0:DEPTH-1];

  logic [31:0]        cycles_q;
  logic [31:0]        gpio_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW-1:0] wptr_q;
  logic [CW-1:0]      count_q;
  logic               ovf_q;

  logic               in_ram;
  logic               in_mmio;
  logic [AW-1:0]      idx;
  logic [1:0]         reg_sel;
  logic               wr_ram;
  logic               wr_gpio;
  logic               wr_txdata;
  logic               wr_txstat;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic               ovf_clr;
  logic [31:0]        count_ext;
  logic [2:0]         count_field;
  logic [31:0]        txstat;
  logic               unused_addr_bits;

  // Address decode; byte-offset bits and RAM alias bits are deliberately ignored.
  assign in_ram  = (a[31:16] == 16'h0000);
  assign in_mmio = (a[31:4] == 28'hFFFF000);
  assign idx     = a[AW+1:2];
  assign reg_sel = a[3:2];
  assign unused_addr_bits = ^{a[15:AW+2], a[1:0]};

  assign wr_ram    = we && in_ram;
  assign wr_gpio   = we && in_mmio && (reg_sel == RegGpio);
  assign wr_txdata = we && in_mmio && (reg_sel == RegTxData);
  assign wr_txstat = we && in_mmio && (reg_sel == RegTxStat);

  // FIFO handshake: a pop frees a slot on the same edge, so a full FIFO can still accept.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rptr_q];
  assign pop      = tx_valid && tx_ready;
  assign push     = wr_txdata && (!full || pop);
  assign drop     = wr_txdata && !push;
  assign ovf_clr  = wr_txstat && wd[2];

  assign gpio_out = gpio_q;

  // Status word; the count field is only 3 bits wide and saturates at 7.
  always_comb begin
    count_ext   = 32'(count_q);
    count_field = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    txstat      = {25'b0, count_field, 1'b0, ovf_q, empty, full};
  end

  // Combinational read mux over RAM and MMIO page; unmapped reads return 0.
  always_comb begin
    rd = '0;
    if (in_ram) begin
      rd = mem[idx];
    end else if (in_mmio) begin
      unique case (reg_sel)
        RegCycles: rd = cycles_q;
        RegGpio:   rd = gpio_q;
        RegTxData: rd = '0;
        RegTxStat: rd = txstat;
        default:   rd = '0;
      endcase
    end
  end

  // RAM write port; contents are not reset but reset still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_ram) begin
      mem[idx] <= wd;
    end
  end

  // FIFO storage write; storage itself needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wptr_q] <= wd[7:0];
    end
  end

  // Counter, GPIO, FIFO pointers/count and sticky overflow; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
      gpio_q   <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (wr_gpio) begin
        gpio_q <= wd;
      end
      if (push) begin
        wptr_q <= wptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + FIFO_AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      // Set wins over clear on the same edge.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: a vector table for RAM/GPIO/FIFO traffic
// plus hand-written sequences for reset, full push+pop, counter wrap and
// reset with bytes queued.
module tb_dmem_mmio;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] ACyc  = 32'hFFFF_0000;
  localparam logic [31:0] AGpio = 32'hFFFF_0004;
  localparam logic [31:0] ATxd  = 32'hFFFF_0008;
  localparam logic [31:0] ATxs  = 32'hFFFF_000C;

  // chk bits: [0] rd, [1] gpio_out, [2] tx_valid, [3] tx_data
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic [3:0]  chk;
    logic [31:0] erd;
    logic [31:0] egpio;
    logic        evalid;
    logic [7:0]  edata;
  } vec_t;

  vec_t vecs[22];

  dmem_mmio #(.AW(6), .FIFO_AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .wd       (wd),
    .we       (we),
    .rd       (rd),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] addr, input logic [31:0] data,
                       input logic rdy);
    we       = w;
    a        = addr;
    wd       = data;
    tx_ready = rdy;
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    we       = 1'b0;
    a        = '0;
    wd       = '0;
    tx_ready = 1'b0;

    //           we    a                wd             rdy   chk    erd            egpio          ev    ed
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 4'b0001, 32'hDEAD_BEEF, 32'h0,         1'b0, 8'h00};
    vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b0, 4'b0001, 32'hDEAD_BEEF, 32'h0,         1'b0, 8'h00};
    vecs[3]  = '{1'b0, 32'h1234_0000, 32'h0,         1'b0, 4'b0001, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[4]  = '{1'b1, AGpio,         32'hA5A5_0001, 1'b0, 4'b0010, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[5]  = '{1'b0, AGpio,         32'h0,         1'b0, 4'b0011, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, ACyc,          32'h0,         1'b0, 4'b0001, 32'd12,        32'h0,         1'b0, 8'h00};
    vecs[7]  = '{1'b0, ACyc,          32'h0,         1'b0, 4'b0001, 32'd13,        32'h0,         1'b0, 8'h00};
    vecs[8]  = '{1'b1, ATxd,          32'h11,        1'b0, 4'b0100, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[9]  = '{1'b1, ATxd,          32'h22,        1'b0, 4'b1100, 32'h0,         32'h0,         1'b1, 8'h11};
    vecs[10] = '{1'b1, ATxd,          32'h33,        1'b0, 4'b1100, 32'h0,         32'h0,         1'b1, 8'h11};
    vecs[11] = '{1'b1, ATxd,          32'h44,        1'b0, 4'b0001, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[12] = '{1'b0, ATxs,          32'h0,         1'b0, 4'b0001, 32'h41,        32'h0,         1'b0, 8'h00};
    vecs[13] = '{1'b1, ATxd,          32'h55,        1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 8'h00};
    vecs[14] = '{1'b0, ATxs,          32'h0,         1'b0, 4'b0001, 32'h45,        32'h0,         1'b0, 8'h00};
    vecs[15] = '{1'b1, ATxs,          32'h4,         1'b0, 4'b0001, 32'h45,        32'h0,         1'b0, 8'h00};
    vecs[16] = '{1'b0, ATxs,          32'h0,         1'b0, 4'b1101, 32'h41,        32'h0,         1'b1, 8'h11};
    vecs[17] = '{1'b0, ATxs,          32'h0,         1'b1, 4'b1101, 32'h41,        32'h0,         1'b1, 8'h11};
    vecs[18] = '{1'b0, ATxs,          32'h0,         1'b1, 4'b1101, 32'h30,        32'h0,         1'b1, 8'h22};
    vecs[19] = '{1'b0, ATxs,          32'h0,         1'b1, 4'b1101, 32'h20,        32'h0,         1'b1, 8'h33};
    vecs[20] = '{1'b0, ATxs,          32'h0,         1'b1, 4'b1101, 32'h10,        32'h0,         1'b1, 8'h44};
    vecs[21] = '{1'b0, ATxs,          32'h0,         1'b1, 4'b0101, 32'h02,        32'h0,         1'b0, 8'h00};

    // Reset, then release; first post-reset cycle is cycle 0.
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, ACyc, 32'h0, 1'b0);
    check("cycles_at_0", rd, 32'd0);
    check("gpio_reset", gpio_out, 32'h0);
    check("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
    tick();
    drive(1'b0, ATxs, 32'h0, 1'b0);
    check("txstat_reset", rd, 32'h2);
    tick();
    tick();
    tick();
    tick();
    drive(1'b0, ACyc, 32'h0, 1'b0);
    check("cycles_at_5", rd, 32'd5);
    tick();

    // Vector table: inputs applied, pre-edge outputs compared, then one edge.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rdy);
      if (vecs[i].chk[0]) check($sformatf("vec%0d_rd", i), rd, vecs[i].erd);
      if (vecs[i].chk[1]) check($sformatf("vec%0d_gpio", i), gpio_out, vecs[i].egpio);
      if (vecs[i].chk[2]) check($sformatf("vec%0d_valid", i), {31'b0, tx_valid},
                                {31'b0, vecs[i].evalid});
      if (vecs[i].chk[3]) check($sformatf("vec%0d_data", i), {24'b0, tx_data},
                                {24'b0, vecs[i].edata});
      tick();
    end

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ATxd, 32'hA1 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, ATxd, 32'hA5, 1'b1);
    check("pp_head_before", {24'b0, tx_data}, 32'hA1);
    check("pp_txstat_before", rd, 32'h0);
    tick();
    drive(1'b0, ATxs, 32'h0, 1'b0);
    check("pp_txstat_after", rd, 32'h41);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ATxs, 32'h0, 1'b1);
      check($sformatf("pp_drain%0d", i), {24'b0, tx_data}, 32'hA2 + 32'(i));
      tick();
    end
    drive(1'b0, ATxs, 32'h0, 1'b0);
    check("pp_empty_after", rd, 32'h2);

    // Cycle counter wrap.
    force dut.cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_q;
    drive(1'b0, ACyc, 32'h0, 1'b0);
    check("wrap_fffe", rd, 32'hFFFF_FFFE);
    tick();
    check("wrap_ffff", rd, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", rd, 32'h0);

    // Reset with three bytes queued and the consumer ready on the reset edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ATxd, 32'hB1 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, ATxs, 32'h0, 1'b0);
    check("rst_q3_txstat", rd, 32'h30);
    reset = 1'b1;
    drive(1'b1, ATxd, 32'hCC, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, ATxs, 32'h0, 1'b0);
    check("rst_q3_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_q3_txstat_after", rd, 32'h2);
    check("rst_q3_gpio", gpio_out, 32'h0);
    drive(1'b0, ACyc, 32'h0, 1'b0);
    check("rst_q3_cycles", rd, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle RV32 core. It services the core's data-memory port (address, write data, write enable, read data) and decodes it into a word RAM plus a memory-mapped peripheral page. The page holds a free-running cycle counter, a general-purpose output register, and a byte TX FIFO drained over a valid/ready handshake. Reads are combinational, as the single-cycle core requires; all state changes occur on the rising clock edge.

## Interface
- `AW`, 6: RAM word-address bits; the RAM holds 2**AW 32-bit words.
- `FIFO_AW`, 2: TX FIFO address bits; depth is 2**FIFO_AW entries (minimum depth 2).
- `clk`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  32  byte address, driven from the core's ALUResult.
- `wd`  in  32  write data, driven from the core's WriteData.
- `we`  in  1  write enable, driven from the core's MemWrite.
- `rd`  out  32  read data, combinational, to the core's ReadData.
- `gpio_out`  out  32  GPIO register value.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte.

## Operation
- Decode. `a[1:0]` is ignored; all accesses are whole words.
- RAM region: `a[31:16]==16'h0000`.
  - Index is `a[AW+1:2]`; higher address bits alias.
  - Write `mem[idx]<=wd` when `we`.
  - `rd=mem[idx]`.
- MMIO region: `a[31:4]==28'hFFFF000`, selected by `a[3:2]`.
  - 0x0 CYCLES (RO): read returns the counter; writes are ignored.
  - 0x4 GPIO (RW): a write loads `wd`; a read returns the register.
  - 0x8 TXDATA (WO):
    - A write pushes `wd[7:0]`.
    - If the FIFO is full and no pop happens this cycle, the byte is dropped and OVF is set.
    - Reads return 0.
  - 0xC TXSTAT: read returns `{25'b0, count[3:0]... }`, laid out as:
    - bits[6:4] = count, with count saturating at 7 in this field.
    - bit2 = OVF.
    - bit1 = empty.
    - bit0 = full.
    - All other bits read 0.
    - A write with `wd[2]=1` clears OVF; other write bits are ignored.
- Unmapped addresses: read 0; writes have no effect.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps `FFFF_FFFF -> 0`.
- FIFO:
  - Circular buffer with a read pointer, a write pointer, and a count of `FIFO_AW+1` bits.
  - `tx_valid = (count!=0)`.
  - `tx_data = buf[rptr]`, and is held stable while `tx_valid && !tx_ready`.
  - Pop occurs on an edge where `tx_valid && tx_ready`.
  - Push occurs on an edge where a TXDATA write is present and (`count<DEPTH` or pop).
  - Push and pop on the same edge: count is unchanged and both pointers advance.
  - Pushing into an empty FIFO: `tx_valid` rises the next cycle, never the same cycle.
  - Pointers wrap modulo DEPTH.
- OVF: a sticky bit.
  - Set on a dropped push.
  - Cleared by the TXSTAT write or by reset.
  - Set wins over clear on the same edge.

## Timing
- Reset values, applied on the edge where `reset=1`:
  - cycles=0.
  - gpio_out=0.
  - count=0, rptr=0, wptr=0.
  - OVF=0, tx_valid=0.
  - `tx_data` is don't-care while `tx_valid=0`.
  - RAM contents are not reset.
- Reset dominates every concurrent write, push and pop. A reset asserted mid-transfer discards all queued bytes; the consumer must not see a pop completed on that edge.
- Read latency is 0 cycles: `rd` is a function of `a` and the current state only.
- Write latency is 1 edge. A read of the same address in the cycle after a write returns the new value. A same-cycle read returns the old value.
- CYCLES read N cycles after reset deassertion returns N, where the first post-reset cycle reads 0.
- TXSTAT reflects pre-edge state. It does not reflect a push or pop occurring on the same edge.

## Test plan
- Reset, then `reset=0`:
  - CYCLES read at cycle 0 returns 0.
  - CYCLES read at cycle 5 returns 5.
  - `gpio_out=0`, `tx_valid=0`.
  - TXSTAT=0x2.
- RAM:
  - Write 0xDEADBEEF to 0x0000_0010.
  - Next-cycle read returns 0xDEADBEEF.
  - Read of 0x0000_0110 (alias, AW=6) returns 0xDEADBEEF.
  - Read of 0x1234_0000 returns 0.
- GPIO:
  - Write 0xA5A5_0001 to 0xFFFF_0004: `gpio_out` is 0xA5A50001 the next cycle, and a readback matches.
  - A write to CYCLES does not change its count.
- FIFO fill/overflow, with `tx_ready=0`:
  - Push 0x11, 0x22, 0x33, 0x44: TXSTAT=0x41.
  - Push 0x55: TXSTAT=0x45.
  - Write TXSTAT with 0x4: TXSTAT=0x41.
- FIFO drain order, with `tx_ready=1`:
  - `tx_data` sequence is 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - `tx_valid` falls after the 4th pop.
  - TXSTAT=0x2.
- Boundaries:
  - Full FIFO with push and pop on the same edge: push accepted, no OVF, count stays 4.
  - Set CYCLES to wrap by forcing near 0xFFFF_FFFF: it wraps to 0.
  - Assert reset with 3 bytes queued: `tx_valid=0` the next cycle and count=0.
